// File: rtl/mac_pkg.sv
// Shared types and constants for the round-robin MAC scheduler.
// Holds the FSM state encoding, the result tag layout and ID-width helpers.
package mac_pkg;

    // Widest requester ID needed for up to 8 requesters.
    localparam int unsigned MaxIdW = 3;

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StBurst = 1'b1;

    typedef struct packed {
        logic              valid;
        logic [MaxIdW-1:0] id;
        logic              last;
    } tag_t;

    localparam int unsigned TagW = $bits(tag_t);

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_tag_pipe.sv
// Fixed-depth shift register that carries {valid, id, last} alongside the MAC
// pipeline so each result can be re-associated with its owner.
module mac_tag_pipe
    import mac_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [TagW-1:0] push_tag,
    output logic [TagW-1:0] pop_tag
);

    logic [TagW-1:0] stage_q [Depth];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(Depth); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= push_tag;
            for (int i = 1; i < int'(Depth); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign pop_tag = stage_q[Depth-1];

endmodule

// File: rtl/mac_rr_sched.sv
// Round-robin burst scheduler sharing one pipelined MAC between N_REQ requesters.
// Define MAC_SCHED_TIMEOUT_EN to revoke grants that stall for TIMEOUT cycles.
module mac_rr_sched
    import mac_pkg::*;
#(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned INPUT_WIDTH  = 16,
    parameter int unsigned OUTPUT_WIDTH = 40,
    parameter int unsigned MAC_LAT      = 4,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [N_REQ-1:0]               i_req_valid,
    input  logic [N_REQ*INPUT_WIDTH-1:0]   i_req_a,
    input  logic [N_REQ*INPUT_WIDTH-1:0]   i_req_b,
    input  logic [N_REQ-1:0]               i_req_last,
    output logic [N_REQ-1:0]               o_req_ready,
    output logic [INPUT_WIDTH-1:0]         o_mac_a,
    output logic [INPUT_WIDTH-1:0]         o_mac_b,
    output logic                           o_mac_valid,
    input  logic [OUTPUT_WIDTH-1:0]        i_mac_val,
    input  logic                           i_mac_valid,
    output logic [OUTPUT_WIDTH-1:0]        o_res_val,
    output logic                           o_res_valid,
    output logic [$clog2(N_REQ)-1:0]       o_res_id,
    output logic                           o_res_last,
    output logic                           o_timeout,
    output logic [$clog2(N_REQ)-1:0]       o_timeout_id
);

    localparam int unsigned IdW = $clog2(N_REQ);

    logic [0:0]     state_q, state_d;
    logic [IdW-1:0] grant_q, grant_d;
    logic [IdW-1:0] ptr_q, ptr_d;
    logic [IdW-1:0] pick;
    logic [IdW:0]   sum;
    logic           any_valid;
    logic           accept;
    logic           last_beat;
    logic           timeout_hit;

    // Scan offsets from the far end down so the nearest requester after ptr wins.
    always_comb begin
        pick      = '0;
        any_valid = 1'b0;
        sum       = '0;
        for (int i = int'(N_REQ); i >= 1; i--) begin
            sum = {1'b0, ptr_q} + (IdW+1)'(i);
            if (sum >= (IdW+1)'(N_REQ)) begin
                sum = sum - (IdW+1)'(N_REQ);
            end
            if (i_req_valid[sum[IdW-1:0]]) begin
                pick      = sum[IdW-1:0];
                any_valid = 1'b1;
            end
        end
    end

    assign accept    = (state_q == StBurst) && i_req_valid[grant_q];
    assign last_beat = accept && i_req_last[grant_q];

    always_comb begin
        o_req_ready = '0;
        if (state_q == StBurst) begin
            o_req_ready[grant_q] = 1'b1;
        end
    end

    assign o_mac_valid = accept;
    assign o_mac_a     = accept ? i_req_a[grant_q*INPUT_WIDTH +: INPUT_WIDTH] : '0;
    assign o_mac_b     = accept ? i_req_b[grant_q*INPUT_WIDTH +: INPUT_WIDTH] : '0;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            StIdle: begin
                if (any_valid) begin
                    grant_d = pick;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if (last_beat || timeout_hit) begin
                    ptr_d   = grant_q;
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= IdW'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef MAC_SCHED_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] stall_cnt_q, stall_cnt_d;
    logic            timeout_q;
    logic [IdW-1:0]  timeout_id_q;

    always_comb begin
        stall_cnt_d = '0;
        timeout_hit = 1'b0;
        if ((state_q == StBurst) && !accept) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
            if (stall_cnt_d == CntW'(TIMEOUT)) begin
                timeout_hit = 1'b1;
                stall_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt_q  <= '0;
            timeout_q    <= 1'b0;
            timeout_id_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            timeout_q    <= timeout_hit;
            timeout_id_q <= timeout_hit ? grant_q : '0;
        end
    end

    assign o_timeout    = timeout_q;
    assign o_timeout_id = timeout_id_q;
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign o_timeout          = 1'b0;
    assign o_timeout_id       = '0;
    assign unused_timeout_cfg = ^TIMEOUT;
`endif

    tag_t            push_tag;
    tag_t            pop_tag;
    logic [TagW-1:0] pop_bits;
    logic            unused_tag_id;

    always_comb begin
        push_tag       = '0;
        push_tag.valid = accept;
        push_tag.id    = MaxIdW'(grant_q);
        push_tag.last  = last_beat;
    end

    mac_tag_pipe #(
        .Depth (MAC_LAT)
    ) u_tag_pipe (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .push_tag (push_tag),
        .pop_tag  (pop_bits)
    );

    assign pop_tag       = tag_t'(pop_bits);
    assign unused_tag_id = ^pop_tag.id;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_res_valid <= 1'b0;
            o_res_val   <= '0;
            o_res_id    <= '0;
            o_res_last  <= 1'b0;
        end else begin
            o_res_valid <= i_mac_valid;
            if (i_mac_valid) begin
                o_res_val  <= i_mac_val;
                o_res_id   <= pop_tag.id[IdW-1:0];
                o_res_last <= pop_tag.last;
            end
        end
    end

    // A MAC result with no matching issued beat (or vice versa) breaks the tag association.
    assert property (@(posedge i_clk) disable iff (i_rst) i_mac_valid == pop_tag.valid)
        else $error("mac_rr_sched: MAC result valid disagrees with tag pipe");

endmodule

// File: tb/tb_mac_rr_sched.sv
// Bench for mac_rr_sched: directed scenarios plus random bursts against a
// cycle-level scheduler model; a behavioural MAC returns a*b after MAC_LAT cycles.
module tb_mac_rr_sched;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int OW  = 40;
    localparam int LAT = 4;
    localparam int TO  = 16;
    localparam int IW  = $clog2(N);

    typedef struct {
        int              due;
        logic [OW-1:0]   val;
        int              id;
        bit              last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*W-1:0]    req_a;
    logic [N*W-1:0]    req_b;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic [W-1:0]      mac_a;
    logic [W-1:0]      mac_b;
    logic              mac_issue;
    logic [OW-1:0]     mac_val;
    logic              mac_valid;
    logic [OW-1:0]     res_val;
    logic              res_valid;
    logic [IW-1:0]     res_id;
    logic              res_last;
    logic              timeout;
    logic [IW-1:0]     timeout_id;

    always #5 clk = ~clk;

    mac_rr_sched #(
        .N_REQ        (N),
        .INPUT_WIDTH  (W),
        .OUTPUT_WIDTH (OW),
        .MAC_LAT      (LAT),
        .TIMEOUT      (TO)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .i_req_last   (req_last),
        .o_req_ready  (req_ready),
        .o_mac_a      (mac_a),
        .o_mac_b      (mac_b),
        .o_mac_valid  (mac_issue),
        .i_mac_val    (mac_val),
        .i_mac_valid  (mac_valid),
        .o_res_val    (res_val),
        .o_res_valid  (res_valid),
        .o_res_id     (res_id),
        .o_res_last   (res_last),
        .o_timeout    (timeout),
        .o_timeout_id (timeout_id)
    );

    // Behavioural MAC: product of the issued operands, LAT cycles later.
    logic          mv   [LAT];
    logic [OW-1:0] mres [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) mv[i] <= 1'b0;
        end else begin
            mv[0]   <= mac_issue;
            mres[0] <= OW'(mac_a) * OW'(mac_b);
            for (int i = 1; i < LAT; i++) begin
                mv[i]   <= mv[i-1];
                mres[i] <= mres[i-1];
            end
        end
    end

    assign mac_valid = mv[LAT-1];
    assign mac_val   = mres[LAT-1];

    // Reference model state: owner of the current grant (-1 when idle), rr pointer.
    int          owner, ptr, cyc, stall_n, to_cnt, exp_to_id;
    bit          exp_to;
    int          left [N];
    logic [W-1:0] cur_a [N];
    logic [W-1:0] cur_b [N];
    exp_t        res_q [$];
    int          nvec = 0;
    int          nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner  = -1;
        ptr    = N - 1;
        stall_n = 0;
        to_cnt = 0;
        exp_to = 1'b0;
        exp_to_id = 0;
        res_q.delete();
        for (int k = 0; k < N; k++) left[k] = 0;
    endtask

    task automatic start_burst(input int k, input int len);
        if (left[k] == 0) begin
            left[k]  = len;
            cur_a[k] = W'($urandom);
            cur_b[k] = W'($urandom);
        end
    endtask

    function automatic int search();
        for (int i = 1; i <= N; i++) begin
            if (req_valid[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    function automatic bit all_quiet();
        int busy = 0;
        for (int k = 0; k < N; k++) busy += left[k];
        return (busy == 0) && (owner < 0) && (res_q.size() == 0);
    endfunction

    task automatic tick();
        bit           acc;
        int           g;
        logic [N-1:0] exp_ready;
        exp_t         e;
        for (int k = 0; k < N; k++) begin
            req_valid[k]         = (left[k] > 0) && !(k == owner && stall_n > 0);
            req_last[k]          = (left[k] == 1);
            req_a[k*W +: W]      = cur_a[k];
            req_b[k*W +: W]      = cur_b[k];
        end
        @(negedge clk);
        exp_ready = '0;
        if (owner >= 0) exp_ready[owner] = 1'b1;
        acc = (owner >= 0) && req_valid[owner];
        chk("ready", req_ready, exp_ready);
        chk("mac_valid", mac_issue, acc);
        if (acc) begin
            chk("mac_a", mac_a, cur_a[owner]);
            chk("mac_b", mac_b, cur_b[owner]);
        end
        if (res_q.size() > 0 && res_q[0].due == cyc) begin
            e = res_q.pop_front();
            chk("res_valid", res_valid, 1);
            chk("res_val", res_val, e.val);
            chk("res_id", res_id, e.id);
            chk("res_last", res_last, e.last);
        end else begin
            chk("res_valid", res_valid, 0);
        end
        chk("timeout", timeout, exp_to);
        chk("timeout_id", timeout_id, exp_to ? exp_to_id : 0);
        exp_to = 1'b0;
        if (rst) begin
            model_reset();
        end else if (acc) begin
            res_q.push_back('{cyc + LAT + 1, OW'(cur_a[owner]) * OW'(cur_b[owner]),
                              owner, left[owner] == 1});
            to_cnt = 0;
            if (left[owner] == 1) begin
                left[owner] = 0;
                ptr   = owner;
                owner = -1;
            end else begin
                left[owner]--;
                cur_a[owner] = W'($urandom);
                cur_b[owner] = W'($urandom);
            end
        end else if (owner >= 0) begin
            if (stall_n > 0) stall_n--;
`ifdef MAC_SCHED_TIMEOUT_EN
            to_cnt++;
            if (to_cnt == TO) begin
                exp_to    = 1'b1;
                exp_to_id = owner;
                ptr       = owner;
                owner     = -1;
                to_cnt    = 0;
            end
`endif
        end else begin
            g = search();
            if (g >= 0) begin
                owner  = g;
                to_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 80; i++) begin
            if (all_quiet()) break;
            tick();
        end
        chk("drain_done", all_quiet(), 1);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_a     = '0;
        req_b     = '0;
        cyc       = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_mac_valid", mac_issue, 0);
        chk("rst_mac_a", mac_a, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_val", res_val, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_last", res_last, 0);
        chk("rst_timeout", timeout, 0);
        @(posedge clk);
        #1;

        // Single beat from req0, 3*5
        start_burst(0, 1);
        cur_a[0] = 16'd3;
        cur_b[0] = 16'd5;
        repeat (8) tick();
        drain();

        // req1 and req2 with 3-beat bursts
        start_burst(1, 3);
        start_burst(2, 3);
        repeat (14) tick();
        drain();

        // All requesters continuously valid with 1-beat bursts
        for (int c = 0; c < 16; c++) begin
            for (int k = 0; k < N; k++) start_burst(k, 1);
            tick();
        end
        drain();

        // req0 stalls 5 cycles mid-burst while req1 waits
        start_burst(0, 4);
        for (int i = 0; i < 10; i++) begin
            if (owner == 0 && left[0] == 3) break;
            tick();
        end
        stall_n = 5;
        start_burst(1, 1);
        repeat (15) tick();
        drain();

        // Reset with two beats in flight
        start_burst(1, 4);
        for (int i = 0; i < 10; i++) begin
            if (left[1] == 2) break;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start_burst(0, 1);
        start_burst(2, 1);
        repeat (12) tick();
        drain();

`ifdef MAC_SCHED_TIMEOUT_EN
        // req2 stalls for TIMEOUT cycles; req3 should win next
        start_burst(2, 3);
        for (int i = 0; i < 10; i++) begin
            if (owner == 2 && left[2] == 2) break;
            tick();
        end
        stall_n = TO;
        start_burst(3, 1);
        repeat (TO + 6) tick();
        drain();
`endif

        // Random bursts with short stalls
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++) begin
                if (left[k] == 0 && $urandom_range(0, 99) < 15) start_burst(k, $urandom_range(1, 4));
            end
            if (owner >= 0 && stall_n == 0 && $urandom_range(0, 9) == 0) stall_n = $urandom_range(1, 3);
            tick();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
